// File: rtl/pwm_dead_time.sv
// pwm_dead_time: complementary high/low gate drive with a programmable dead band.
// Optional latched fault shutdown is compiled in with `define PWM_DT_FAULT_EN.
module pwm_dead_time #(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                enable_ni,
   input  logic                pwm_i,
   input  logic [DT_WIDTH-1:0] dead_time_i,
`ifdef PWM_DT_FAULT_EN
   input  logic                fault_i,
   input  logic                fault_clr_i,
   output logic                fault_o,
`endif
   output logic                high_o,
   output logic                low_o,
   output logic                busy_o
);

   localparam logic [2:0] S_OFF     = 3'd0;
   localparam logic [2:0] S_LOW_ON  = 3'd1;
   localparam logic [2:0] S_DEAD_LH = 3'd2;
   localparam logic [2:0] S_HIGH_ON = 3'd3;
   localparam logic [2:0] S_DEAD_HL = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [DT_WIDTH-1:0] r_cnt;
   logic [DT_WIDTH-1:0] w_cnt_nxt;
   logic [DT_WIDTH-1:0] w_dt_m1;
   logic                w_dt_zero;
   logic                w_halt;
   logic                r_high;
   logic                r_low;
   logic                r_busy;

   assign w_dt_zero = (dead_time_i == {DT_WIDTH{1'b0}});
   assign w_dt_m1   = dead_time_i - DT_WIDTH'(1);

`ifdef PWM_DT_FAULT_EN
   logic r_fault;

   // Fault flag: set wins over clear, clear only acts without a fault request.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_fault <= 1'b0;
      end else if (fault_i) begin
         r_fault <= 1'b1;
      end else if (fault_clr_i) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= r_fault;
      end
   end

   assign w_halt  = fault_i | r_fault;
   assign fault_o = r_fault;
`else
   assign w_halt  = 1'b0;
`endif

   // Next-state and dead-band counter; aborts only fall back to the side last on.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_halt || enable_ni) begin
         w_state_nxt = S_OFF;
      end else begin
         case (r_state)
            S_OFF: begin
               if (w_dt_zero) begin
                  w_state_nxt = pwm_i ? S_HIGH_ON : S_LOW_ON;
               end else begin
                  w_state_nxt = pwm_i ? S_DEAD_LH : S_DEAD_HL;
                  w_cnt_nxt   = w_dt_m1;
               end
            end
            S_LOW_ON: begin
               if (pwm_i && w_dt_zero) begin
                  w_state_nxt = S_HIGH_ON;
               end else if (pwm_i) begin
                  w_state_nxt = S_DEAD_LH;
                  w_cnt_nxt   = w_dt_m1;
               end else begin
                  w_state_nxt = S_LOW_ON;
               end
            end
            S_HIGH_ON: begin
               if (!pwm_i && w_dt_zero) begin
                  w_state_nxt = S_LOW_ON;
               end else if (!pwm_i) begin
                  w_state_nxt = S_DEAD_HL;
                  w_cnt_nxt   = w_dt_m1;
               end else begin
                  w_state_nxt = S_HIGH_ON;
               end
            end
            S_DEAD_LH: begin
               if (!pwm_i) begin
                  w_state_nxt = S_LOW_ON;
               end else if (r_cnt == {DT_WIDTH{1'b0}}) begin
                  w_state_nxt = S_HIGH_ON;
               end else begin
                  w_cnt_nxt   = r_cnt - DT_WIDTH'(1);
               end
            end
            S_DEAD_HL: begin
               if (pwm_i) begin
                  w_state_nxt = S_HIGH_ON;
               end else if (r_cnt == {DT_WIDTH{1'b0}}) begin
                  w_state_nxt = S_LOW_ON;
               end else begin
                  w_cnt_nxt   = r_cnt - DT_WIDTH'(1);
               end
            end
            default: begin
               w_state_nxt = S_OFF;
            end
         endcase
      end
   end

   // State, counter and gate outputs; outputs are decoded from the next state
   // so they are flops yet still track the state register cycle for cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_OFF;
         r_cnt   <= {DT_WIDTH{1'b0}};
         r_high  <= 1'b0;
         r_low   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_high  <= (w_state_nxt == S_HIGH_ON);
         r_low   <= (w_state_nxt == S_LOW_ON);
         r_busy  <= (w_state_nxt == S_DEAD_LH) || (w_state_nxt == S_DEAD_HL);
      end
   end

   assign high_o = r_high;
   assign low_o  = r_low;
   assign busy_o = r_busy;

endmodule

// File: tb/tb_pwm_dead_time.sv
// Directed self-checking bench for pwm_dead_time; fault steps run when
// PWM_DT_FAULT_EN is defined for both bench and design.
module tb_pwm_dead_time;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       enable_ni;
   logic       pwm_i;
   logic [7:0] dead_time_i;
   logic       high_o;
   logic       low_o;
   logic       busy_o;
`ifdef PWM_DT_FAULT_EN
   logic       fault_i;
   logic       fault_clr_i;
   logic       fault_o;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int busy_cnt;
   int guard;

   pwm_dead_time #(.DT_WIDTH(8)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enable_ni   (enable_ni),
      .pwm_i       (pwm_i),
      .dead_time_i (dead_time_i),
`ifdef PWM_DT_FAULT_EN
      .fault_i     (fault_i),
      .fault_clr_i (fault_clr_i),
      .fault_o     (fault_o),
`endif
      .high_o      (high_o),
      .low_o       (low_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Overlap invariant sampled every cycle on the inactive edge.
   always @(negedge clk_i) begin
      n_total++;
      assert (!(high_o && low_o)) n_pass++;
      else $error("FAIL overlap observed h=%b l=%b expected not both 1", high_o, low_o);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] exp);
      n_total++;
      assert ({high_o, low_o, busy_o} === exp) n_pass++;
      else $error("FAIL %s observed hlb=%b expected hlb=%b", tag, {high_o, low_o, busy_o}, exp);
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      reset_i = 1'b1; enable_ni = 1'b1; pwm_i = 1'b0; dead_time_i = 8'd4;
`ifdef PWM_DT_FAULT_EN
      fault_i = 1'b0; fault_clr_i = 1'b0;
`endif
      step(); step();
      chk("reset", 3'b000);
`ifdef PWM_DT_FAULT_EN
      chk_int("reset_fault", int'(fault_o), 0);
`endif

      // Enable with pwm low: 4-cycle dead band then low side.
      reset_i = 1'b0; enable_ni = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); chk("startup_dead", 3'b001); end
      step(); chk("startup_low", 3'b010);

      // Rising edge with D=3, then falling edge with D=3.
      dead_time_i = 8'd3; pwm_i = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); chk("rise_dead", 3'b001); end
      step(); chk("rise_high", 3'b100);
      pwm_i = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); chk("fall_dead", 3'b001); end
      step(); chk("fall_low", 3'b010);

      // Short high pulse (2 cycles) inside a D=5 band aborts back to low.
      dead_time_i = 8'd5; pwm_i = 1'b1;
      step(); chk("short_hi_dead0", 3'b001);
      step(); chk("short_hi_dead1", 3'b001);
      pwm_i = 1'b0;
      step(); chk("short_hi_abort", 3'b010);
      step(); chk("short_hi_hold", 3'b010);

      // Reach HIGH_ON with D=2, then mirrored short low pulse with D=5.
      dead_time_i = 8'd2; pwm_i = 1'b1;
      step(); chk("to_high_dead0", 3'b001);
      step(); chk("to_high_dead1", 3'b001);
      step(); chk("to_high_on", 3'b100);
      dead_time_i = 8'd5; pwm_i = 1'b0;
      step(); chk("short_lo_dead0", 3'b001);
      step(); chk("short_lo_dead1", 3'b001);
      pwm_i = 1'b1;
      step(); chk("short_lo_abort", 3'b100);

      // D=0 square wave of period 8: exact complements, no gap.
      dead_time_i = 8'd0;
      for (int i = 0; i < 16; i++) begin
         pwm_i = ((i / 4) % 2 == 0) ? 1'b0 : 1'b1;
         step(); chk("d0_square", {pwm_i, ~pwm_i, 1'b0});
      end

      // Disable mid DEAD_HL, then re-enable with D=3.
      dead_time_i = 8'd6; pwm_i = 1'b0;
      step(); chk("dis_dead0", 3'b001);
      step(); chk("dis_dead1", 3'b001);
      enable_ni = 1'b1;
      step(); chk("dis_off", 3'b000);
      step(); chk("dis_off_hold", 3'b000);
      dead_time_i = 8'd3; enable_ni = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); chk("reen_dead", 3'b001); end
      step(); chk("reen_low", 3'b010);

      // OFF entered with D=0 goes straight to the pwm side.
      enable_ni = 1'b1;
      step(); chk("off_d0_off", 3'b000);
      dead_time_i = 8'd0; pwm_i = 1'b1; enable_ni = 1'b0;
      step(); chk("off_d0_high", 3'b100);

      // Reset mid dead band, then restart through a full band.
      dead_time_i = 8'd4; pwm_i = 1'b0;
      step(); chk("rst_mid_dead", 3'b001);
      reset_i = 1'b1;
      step(); chk("rst_mid_off", 3'b000);
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); chk("rst_restart_dead", 3'b001); end
      step(); chk("rst_restart_low", 3'b010);

      // Maximum dead band of 255 cycles.
      dead_time_i = 8'd255; pwm_i = 1'b1;
      step();
      busy_cnt = 0; guard = 0;
      while (busy_o && guard < 300) begin busy_cnt++; guard++; step(); end
      chk_int("max_dead_len", busy_cnt, 255);
      chk("max_dead_high", 3'b100);

`ifdef PWM_DT_FAULT_EN
      // Fault in HIGH_ON latches and holds through pwm toggles.
      fault_i = 1'b1;
      step(); chk("flt_off", 3'b000); chk_int("flt_set", int'(fault_o), 1);
      fault_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pwm_i = ~pwm_i;
         step(); chk("flt_hold", 3'b000); chk_int("flt_hold_flag", int'(fault_o), 1);
      end
      fault_i = 1'b1; fault_clr_i = 1'b1;
      step(); chk_int("flt_both_wins", int'(fault_o), 1);
      fault_i = 1'b0; dead_time_i = 8'd2; pwm_i = 1'b0;
      step(); chk_int("flt_clr", int'(fault_o), 0); chk("flt_clr_off", 3'b000);
      fault_clr_i = 1'b0;
      step(); chk("flt_restart_dead0", 3'b001);
      step(); chk("flt_restart_dead1", 3'b001);
      step(); chk("flt_restart_low", 3'b010);
`endif

      // Random pwm/dead-time stress; overlap monitor checks every cycle.
      for (int i = 0; i < 300; i++) begin
         pwm_i = 1'($urandom_range(1, 0));
         dead_time_i = 8'($urandom_range(3, 0));
         enable_ni = ($urandom_range(19, 0) == 0) ? 1'b1 : 1'b0;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
